// File: rtl/cv32e40x_pma_prog_pkg.sv
// Types and constants for the programmable PMA.
// - pma_cfg_t: one region entry. The bounds are word addresses; low is
//   inclusive and high is exclusive.
// - pma_req_t / pma_rsp_t: lookup request and response.
// - Default attribute sets for a miss, for a table-less build, and for debug.
package cv32e40x_pma_prog_pkg;

    typedef enum logic [1:0] {A_NONE, ZALRSC, A} a_ext_e;

    localparam int unsigned PMA_MAX_REGIONS = 16;
    // The region field is wide enough for index 0..16, where 16 means "no hit".
    localparam int unsigned PMA_RGN_W = 5;

    typedef struct packed {
        logic [31:0] word_addr_low;
        logic [31:0] word_addr_high;
        logic        main;
        logic        bufferable;
        logic        cacheable;
        logic        atomic;
    } pma_cfg_t;

    localparam pma_cfg_t PMA_R_DEFAULT    = '{word_addr_low: '0, word_addr_high: '0,
                                              main: 1'b0, bufferable: 1'b0,
                                              cacheable: 1'b0, atomic: 1'b0};
    localparam pma_cfg_t NO_PMA_R_DEFAULT = '{word_addr_low: '0, word_addr_high: '0,
                                              main: 1'b1, bufferable: 1'b0,
                                              cacheable: 1'b0, atomic: 1'b1};
    localparam pma_cfg_t PMA_R_DEBUG      = '{word_addr_low: '0, word_addr_high: '0,
                                              main: 1'b1, bufferable: 1'b0,
                                              cacheable: 1'b0, atomic: 1'b0};

    typedef enum logic {PMA_SEARCH_PAR, PMA_SEARCH_SEQ} pma_search_e;
    typedef enum logic [1:0] {IDLE, SEARCH, RESP} pma_seq_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        debug_region;
        logic        pushpop;
        logic        instr_fetch;
        logic        atomic;
        logic        misaligned;
        logic        modified;
        logic        load;
    } pma_req_t;

    typedef struct packed {
        logic                 err;
        logic                 bufferable;
        logic                 cacheable;
        logic                 hit;
        logic [PMA_RGN_W-1:0] region;
    } pma_rsp_t;

    // Sizes the reset-table parameter. At least one entry is kept so that a
    // build with zero regions still has a legal array range.
    function automatic int unsigned pma_nr_store(int unsigned n);
        return (n > 0) ? n : 1;
    endfunction

endpackage

// File: rtl/cv32e40x_pma_prog_if.sv
// Lookup and table-write bus of the programmable PMA.
// - slave: the PMA side.
// - master: the requester / configuration side.
// Signal names keep their _i/_o suffixes as seen from the PMA.
interface cv32e40x_pma_prog_if;
    import cv32e40x_pma_prog_pkg::*;

    logic       req_valid_i;
    logic       req_ready_o;
    pma_req_t   req_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    pma_rsp_t   rsp_o;
    logic       cfg_we_i;
    logic       cfg_ready_o;
    logic [3:0] cfg_idx_i;
    pma_cfg_t   cfg_wdata_i;
    logic       cfg_lock_i;
    logic       cfg_err_o;

    modport slave (
        input  req_valid_i, req_i, rsp_ready_i, cfg_we_i, cfg_idx_i, cfg_wdata_i, cfg_lock_i,
        output req_ready_o, rsp_valid_o, rsp_o, cfg_ready_o, cfg_err_o
    );
    modport master (
        output req_valid_i, req_i, rsp_ready_i, cfg_we_i, cfg_idx_i, cfg_wdata_i, cfg_lock_i,
        input  req_ready_o, rsp_valid_o, rsp_o, cfg_ready_o, cfg_err_o
    );
endinterface

// File: rtl/cv32e40x_pma_prog_attr_check.sv
// Combinational attribute evaluation for one resolved region config and one request.
// Inputs:  cfg_i (selected region attributes), req_i (access type).
// Outputs: err_o, bufferable_o, cacheable_o.
// Without the atomic extension the region's atomic attribute reads as 0.
module cv32e40x_pma_prog_attr_check
    import cv32e40x_pma_prog_pkg::*;
#(
    parameter a_ext_e A_EXT = A_NONE
) (
    input  pma_cfg_t cfg_i,
    input  pma_req_t req_i,
    output logic     err_o,
    output logic     bufferable_o,
    output logic     cacheable_o
);
    logic atomic_attr;
    logic unused_bits;

    assign atomic_attr  = (A_EXT != A_NONE) && cfg_i.atomic;

    assign err_o        = (req_i.atomic && !atomic_attr) ||
                          ((req_i.instr_fetch || req_i.misaligned || req_i.modified ||
                            req_i.pushpop) && !cfg_i.main);

    assign bufferable_o = cfg_i.bufferable && !req_i.instr_fetch && !req_i.atomic && !req_i.load;
    assign cacheable_o  = cfg_i.cacheable;

    // Region bounds and address are resolved upstream.
    assign unused_bits  = ^{cfg_i.word_addr_low, cfg_i.word_addr_high, req_i.addr,
                            req_i.debug_region};
endmodule

// File: rtl/cv32e40x_pma_prog.sv
// Programmable PMA checker with a runtime-writable table and sticky per-region locks.
// Ports:
//   clk, rst - clock; synchronous active-high reset.
//   bus      - request/response handshake plus table-write channel (slave modport).
// Search modes:
//   PAR - every region is compared in one cycle; the response is registered
//         (latency 1, full throughput).
//   SEQ - one region is compared per cycle through the IDLE/SEARCH/RESP FSM.
//         The table is frozen while the FSM is out of IDLE.
module cv32e40x_pma_prog
    import cv32e40x_pma_prog_pkg::*;
#(
    parameter a_ext_e      A_EXT           = A_NONE,
    parameter int unsigned PMA_NUM_REGIONS = 0,
    parameter pma_cfg_t [pma_nr_store(PMA_NUM_REGIONS)-1:0] PMA_CFG = '{default: PMA_R_DEFAULT},
    parameter pma_search_e SEARCH_MODE     = PMA_SEARCH_PAR
) (
    input logic                clk,
    input logic                rst,
    cv32e40x_pma_prog_if.slave bus
);
    // A table-less build has nothing to scan, so it always uses the single-cycle path.
    localparam bit                   SEQ_EN   = (SEARCH_MODE == PMA_SEARCH_SEQ) && (PMA_NUM_REGIONS > 0);
    localparam pma_cfg_t             MISS_CFG = (PMA_NUM_REGIONS == 0) ? NO_PMA_R_DEFAULT : PMA_R_DEFAULT;
    localparam logic [3:0]           LAST_IDX = 4'(PMA_NUM_REGIONS - 1);
    localparam logic [PMA_RGN_W-1:0] MISS_RGN = PMA_RGN_W'(PMA_NUM_REGIONS);

    function automatic pma_cfg_t reset_entry(int i);
        pma_cfg_t c = PMA_R_DEFAULT;
        for (int j = 0; j < int'(PMA_NUM_REGIONS); j++) if (j == i) c = PMA_CFG[j];
        return c;
    endfunction

    function automatic logic in_rgn(pma_cfg_t c, logic [31:0] wa);
        return (wa >= c.word_addr_low) && (wa < c.word_addr_high);
    endfunction

    // Entries at or above PMA_NUM_REGIONS are never written; they stay constant.
    pma_cfg_t       table_q [PMA_MAX_REGIONS];
    pma_cfg_t       table_d [PMA_MAX_REGIONS];
    logic [15:0]    lock_q, lock_d;
    logic           cfg_err_q, cfg_err_d;
    pma_seq_state_e state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    pma_req_t       req_q, req_d;
    pma_rsp_t       rsp_q, rsp_d;
    logic           rsp_valid_q, rsp_valid_d;

    logic           req_ready, cfg_ready, accept, cfg_acc;
    pma_req_t       lk_req;
    logic [31:0]    word_addr;
    logic           par_hit, seq_hit, hit;
    logic [3:0]     par_idx, sel_idx;
    pma_cfg_t       eff_cfg;
    pma_rsp_t       lk_rsp;
    logic           ac_err, ac_buf, ac_cache;
    logic           unused_addr;

    // In IDLE a pending table write takes precedence over a lookup.
    assign req_ready = SEQ_EN ? ((state_q == IDLE) && !bus.cfg_we_i)
                              : (!rsp_valid_q || bus.rsp_ready_i);
    assign cfg_ready = SEQ_EN ? (state_q == IDLE) : 1'b1;
    assign accept    = bus.req_valid_i && req_ready;
    assign cfg_acc   = bus.cfg_we_i && cfg_ready;

    // Shared lookup. PAR uses the live request against all entries (lowest
    // index wins). SEQ uses the latched request against entry idx_q only.
    always_comb begin
        lk_req    = SEQ_EN ? req_q : bus.req_i;
        word_addr = {2'b00, lk_req.addr[31:2]};
        par_hit   = 1'b0;
        par_idx   = '0;
        for (int i = 0; i < int'(PMA_NUM_REGIONS); i++) begin
            if (!par_hit && in_rgn(table_q[i], word_addr)) begin
                par_hit = 1'b1;
                par_idx = 4'(i);
            end
        end
        seq_hit = in_rgn(table_q[idx_q], word_addr);
        hit     = SEQ_EN ? seq_hit : par_hit;
        sel_idx = SEQ_EN ? idx_q : par_idx;
        if (lk_req.debug_region) eff_cfg = PMA_R_DEBUG;
        else if (hit)            eff_cfg = table_q[sel_idx];
        else                     eff_cfg = MISS_CFG;
    end

    assign unused_addr = ^lk_req.addr[1:0];

    cv32e40x_pma_prog_attr_check #(.A_EXT(A_EXT)) u_attr (
        .cfg_i        (eff_cfg),
        .req_i        (lk_req),
        .err_o        (ac_err),
        .bufferable_o (ac_buf),
        .cacheable_o  (ac_cache)
    );

    always_comb begin
        lk_rsp            = '0;
        lk_rsp.err        = ac_err;
        lk_rsp.bufferable = ac_buf;
        lk_rsp.cacheable  = ac_cache;
        lk_rsp.hit        = hit && !lk_req.debug_region;
        lk_rsp.region     = lk_rsp.hit ? {1'b0, sel_idx} : MISS_RGN;
    end

    // Table writes: rejected for out-of-range or locked entries.
    always_comb begin
        table_d   = table_q;
        lock_d    = lock_q;
        cfg_err_d = 1'b0;
        if (cfg_acc) begin
            if (int'(bus.cfg_idx_i) >= int'(PMA_NUM_REGIONS) || lock_q[bus.cfg_idx_i]) begin
                cfg_err_d = 1'b1;
            end else begin
                table_d[bus.cfg_idx_i] = bus.cfg_wdata_i;
                lock_d[bus.cfg_idx_i]  = bus.cfg_lock_i;
            end
        end
    end

    // Response path. rsp_q only changes when a new result is produced, so
    // it holds while the consumer stalls.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        req_d       = req_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        if (!SEQ_EN) begin
            if (accept) begin
                rsp_d       = lk_rsp;
                rsp_valid_d = 1'b1;
            end else if (bus.rsp_ready_i) begin
                rsp_valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    req_d   = bus.req_i;
                    idx_d   = '0;
                    state_d = SEARCH;
                end
                SEARCH: if (seq_hit || idx_q == LAST_IDX) begin
                    rsp_d       = lk_rsp;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
                RESP: if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PMA_MAX_REGIONS); i++) table_q[i] <= reset_entry(i);
            lock_q      <= '0;
            cfg_err_q   <= 1'b0;
            state_q     <= IDLE;
            idx_q       <= '0;
            req_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            table_q     <= table_d;
            lock_q      <= lock_d;
            cfg_err_q   <= cfg_err_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.cfg_ready_o = cfg_ready;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_o       = rsp_q;
    assign bus.cfg_err_o   = cfg_err_q;
endmodule
